// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and helpers for the horizontal and
// vertical timing generators.
package vga_timing_pkg;

    // Horizontal timing, in pixels
    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;

    // Vertical timing, in lines
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    // Sync pulse active level
    localparam logic POL_LOW  = 1'b0;
    localparam logic POL_HIGH = 1'b1;

    // Full period of one axis: active + front porch + sync + back porch
    function automatic int calc_total(input int a, input int fp, input int s, input int bp);
        return a + fp + s + bp;
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Wrapping modulo counter with enable, synchronous clear and a wrap flag.
// The next-state value is exported so callers can register decodes that
// line up with the count itself.
module mod_counter #(
    parameter int MODULUS = 8,
    parameter int W       = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic [W-1:0] count_next,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(MODULUS - 1);

    // Next count: clear wins over enable; wrap flags the natural roll-over only
    always_comb begin
        count_next = count;
        wrap       = 1'b0;
        if (clr) begin
            count_next = '0;
        end else if (en) begin
            if (count == LAST) begin
                count_next = '0;
                wrap       = 1'b1;
            end else begin
                count_next = count + 1'b1;
            end
        end
    end

    // Count register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/v_timing_gen.sv
// Parametrised vertical timing generator. Counts lines on h_tick & pix_ce and
// registers every decode from the next line number, so all flags change in
// the same cycle as v_count.
module v_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = POL_LOW,
    parameter int   CNT_W    = 10,
    parameter int   FRAME_W  = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               pix_ce,
    input  logic               h_tick,
    input  logic               resync,
    output logic [CNT_W-1:0]   v_count,
    output logic               v_tick,
    output logic               v_sync,
    output logic               v_video,
    output logic               frame_start,
    output logic               vblank_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int V_TOTAL    = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int SYNC_START = V_ACTIVE + V_FP;
    localparam int SYNC_END   = SYNC_START + V_SYNC - 1;

    localparam logic [CNT_W-1:0] ACT_C    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] ACT_M1_C = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] SS_C     = CNT_W'(SYNC_START);
    localparam logic [CNT_W-1:0] SE_C     = CNT_W'(SYNC_END);

    if (V_SYNC < 1 || V_ACTIVE < 1 ||
        (CNT_W < 31 && V_TOTAL > (1 << CNT_W))) begin : g_param_err
        $error("v_timing_gen: need V_SYNC>=1, V_ACTIVE>=1 and V_TOTAL within CNT_W bits");
    end

    logic             adv;
    logic [CNT_W-1:0] line_next;
    logic             line_wrap;

    assign adv = h_tick & pix_ce;

    mod_counter #(
        .MODULUS (V_TOTAL),
        .W       (CNT_W)
    ) u_line (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (adv),
        .clr        (resync),
        .count      (v_count),
        .count_next (line_next),
        .wrap       (line_wrap)
    );

    // Level flags decoded from the next line so they track v_count exactly
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v_video <= 1'b1;
            v_tick  <= 1'b0;
            v_sync  <= ~SYNC_POL;
        end else begin
            v_video <= (line_next < ACT_C);
            v_tick  <= (line_next == LAST_C);
            v_sync  <= (line_next >= SS_C && line_next <= SE_C) ? SYNC_POL : ~SYNC_POL;
        end
    end

    // One-clock event pulses; a resync always restarts the frame, even from line 0
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
        end else begin
            frame_start  <= resync | line_wrap;
            vblank_start <= adv & ~resync & (v_count == ACT_M1_C);
        end
    end

    // Completed-frame counter; only natural wraps count, resync does not
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt <= '0;
        end else if (line_wrap) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_v_timing_gen.sv
// Randomised bench for v_timing_gen: three instances (small active-low,
// small active-high with 2-bit frame counter, full 525-line default) share
// one stimulus stream and are compared against a line-level reference model.
module tb_v_timing_gen;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic pix_ce = 1'b0;
    logic h_tick = 1'b0;
    logic resync = 1'b0;

    always #5 clk = ~clk;

    logic [2:0] vc_a, vc_b;
    logic [9:0] vc_c;
    logic [7:0] fc_a, fc_c;
    logic [1:0] fc_b;
    logic tk_a, sy_a, vd_a, fs_a, vb_a;
    logic tk_b, sy_b, vd_b, fs_b, vb_b;
    logic tk_c, sy_c, vd_c, fs_c, vb_c;

    v_timing_gen #(.V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                   .SYNC_POL(1'b0), .CNT_W(3), .FRAME_W(8)) dut_a (
        .clk(clk), .reset_n(reset_n), .pix_ce(pix_ce), .h_tick(h_tick), .resync(resync),
        .v_count(vc_a), .v_tick(tk_a), .v_sync(sy_a), .v_video(vd_a),
        .frame_start(fs_a), .vblank_start(vb_a), .frame_cnt(fc_a));

    v_timing_gen #(.V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                   .SYNC_POL(1'b1), .CNT_W(3), .FRAME_W(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .pix_ce(pix_ce), .h_tick(h_tick), .resync(resync),
        .v_count(vc_b), .v_tick(tk_b), .v_sync(sy_b), .v_video(vd_b),
        .frame_start(fs_b), .vblank_start(vb_b), .frame_cnt(fc_b));

    v_timing_gen dut_c (
        .clk(clk), .reset_n(reset_n), .pix_ce(pix_ce), .h_tick(h_tick), .resync(resync),
        .v_count(vc_c), .v_tick(tk_c), .v_sync(sy_c), .v_video(vd_c),
        .frame_start(fs_c), .vblank_start(vb_c), .frame_cnt(fc_c));

    // Reference model: one line number and frame count per instance
    typedef struct {
        int va, fp, vs, bp, pol, fw;
        int line, fcnt;
        bit fs, vb;
    } mdl_t;

    mdl_t mdl [3];
    int n_chk  = 0;
    int n_pass = 0;

    function automatic mdl_t mdl_reset(mdl_t m);
        m.line = 0; m.fcnt = 0; m.fs = 0; m.vb = 0;
        return m;
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, bit adv, bit rs);
        int total = m.va + m.fp + m.vs + m.bp;
        m.fs = 0; m.vb = 0;
        if (rs) begin
            m.line = 0;
            m.fs   = 1;
        end else if (adv) begin
            if (m.line == total - 1) begin
                m.line = 0;
                m.fs   = 1;
                m.fcnt = (m.fcnt + 1) % (1 << m.fw);
            end else begin
                m.line = m.line + 1;
                m.vb   = (m.line == m.va);
            end
        end
        return m;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic check_inst(input int i, input string nm, input int vc, input bit tk,
                              input bit sy, input bit vd, input bit fs, input bit vb,
                              input int fc);
        mdl_t m = mdl[i];
        int total = m.va + m.fp + m.vs + m.bp;
        bit in_sync = (m.line >= m.va + m.fp) && (m.line < m.va + m.fp + m.vs);
        check({nm, ".v_count"},      vc, m.line);
        check({nm, ".v_tick"},       int'(tk), int'(m.line == total - 1));
        check({nm, ".v_sync"},       int'(sy), in_sync ? m.pol : 1 - m.pol);
        check({nm, ".v_video"},      int'(vd), int'(m.line < m.va));
        check({nm, ".frame_start"},  int'(fs), int'(m.fs));
        check({nm, ".vblank_start"}, int'(vb), int'(m.vb));
        check({nm, ".frame_cnt"},    fc, m.fcnt);
    endtask

    task automatic check_all();
        check_inst(0, "a", int'(vc_a), tk_a, sy_a, vd_a, fs_a, vb_a, int'(fc_a));
        check_inst(1, "b", int'(vc_b), tk_b, sy_b, vd_b, fs_b, vb_b, int'(fc_b));
        check_inst(2, "c", int'(vc_c), tk_c, sy_c, vd_c, fs_c, vb_c, int'(fc_c));
    endtask

    // One clock: drive on the falling edge, update model on the rising edge, check 1 ns later
    task automatic step(input bit rst_n, input bit ht, input bit pc, input bit rs);
        @(negedge clk);
        reset_n = rst_n;
        h_tick  = ht;
        pix_ce  = pc;
        resync  = rs;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) mdl[i] = mdl_reset(mdl[i]);
            else        mdl[i] = mdl_step(mdl[i], ht & pc, rs);
        end
        #1;
        check_all();
    endtask

    task automatic rand_step(input int adv_pct, input int rs_per);
        bit ht = ($urandom_range(99) < adv_pct) || ($urandom_range(3) == 0);
        bit pc = ($urandom_range(99) < adv_pct) || ($urandom_range(3) == 0);
        bit rs = (rs_per > 0) && ($urandom_range(rs_per - 1) == 0);
        step(1'b1, ht, pc, rs);
    endtask

    initial begin
        mdl[0] = '{va:4, fp:1, vs:2, bp:1, pol:0, fw:8, line:0, fcnt:0, fs:0, vb:0};
        mdl[1] = '{va:4, fp:1, vs:2, bp:1, pol:1, fw:2, line:0, fcnt:0, fs:0, vb:0};
        mdl[2] = '{va:480, fp:10, vs:2, bp:33, pol:0, fw:8, line:0, fcnt:0, fs:0, vb:0};

        // Reset state
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 1'b0);

        // One full small frame of consecutive advances
        for (int k = 0; k < 8; k++) step(1'b1, 1'b1, 1'b1, 1'b0);
        check("a.frame_after_8", int'(fc_a), 1);

        // Half-qualified advances must not move anything
        for (int k = 0; k < 20; k++) step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) step(1'b1, 1'b0, 1'b1, 1'b0);

        // Cross into vertical blank and let the pulse drop
        for (int k = 0; k < 16 && mdl[0].line != 3; k++) step(1'b1, 1'b1, 1'b1, 1'b0);
        check("a.reach_line3", int'(vc_a), 3);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("a.vblank_pulse", int'(vb_a), 1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("a.vblank_drop", int'(vb_a), 0);

        // Resync together with advance at line 6
        for (int k = 0; k < 16 && mdl[0].line != 6; k++) step(1'b1, 1'b1, 1'b1, 1'b0);
        check("a.reach_line6", int'(vc_a), 6);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("a.resync_line0", int'(vc_a), 0);
        check("a.resync_fs", int'(fs_a), 1);
        // Resync while already at line 0 still restarts
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check("a.resync_at0_fs", int'(fs_a), 1);

        // Four back-to-back small frames: 2-bit frame counter wraps
        for (int k = 0; k < 32; k++) step(1'b1, 1'b1, 1'b1, 1'b0);

        // Random traffic with occasional resync
        for (int k = 0; k < 600; k++) rand_step(70, 64);

        // Full-size instance to line 300, then asynchronous reset mid-cycle
        for (int k = 0; k < 1200 && mdl[2].line != 300; k++) step(1'b1, 1'b1, 1'b1, 1'b0);
        check("c.reach_line300", int'(vc_c), 300);
        #2;
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) mdl[i] = mdl_reset(mdl[i]);
        #1;
        check_all();
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Full 525-line frame plus wrap, then random traffic again
        for (int k = 0; k < 530; k++) step(1'b1, 1'b1, 1'b1, 1'b0);
        check("c.frame_after_wrap", int'(fc_c), 1);
        for (int k = 0; k < 400; k++) rand_step(80, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
